fault_inject_seq: RTL and testbench

Programmable fault-injection sequencer that drives the `err[31:0]` corruption vector into `picorv32_wrapper`, replacing hand-timed `#delay` stimulus with a cycle-accurate, reproducible schedule. It alternates quiet (GAP) and corrupting (ACTIVE) windows and selects the corrupted bit(s) from a fixed index or a seeded LFSR. It stops after a programmed number of faults. It sits directly upstream of the core's Hamming/residue checkers, in the same clock domain as the core.

---
 rtl/fault_inject_pkg.sv | 12 +
 rtl/fault_lfsr32.sv | 14 +
 rtl/fault_inject_seq.sv | 75 +++++++
 tb/tb_fault_inject_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fault_inject_pkg.sv
// fault_inject_pkg: shared state encoding, mode codes and LFSR constants for the fault-injection sequencer
package fault_inject_pkg;
  typedef enum logic [1:0] {S_IDLE, S_GAP, S_ACTIVE, S_DONE} state_t;
  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_RAND1 = 2'd1;
  localparam logic [1:0] MODE_RAND2 = 2'd2;
  localparam logic [1:0] MODE_JITTER = 2'd3;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  function automatic logic [15:0] clamp_load(input logic [16:0] v);
    return v == 17'd0 ? 16'd1 : v[16] ? 16'hFFFF : v[15:0];
  endfunction
endpackage

// File: rtl/fault_lfsr32.sv
// fault_lfsr32: 32-bit right-shifting Galois LFSR that never holds zero
module fault_lfsr32 import fault_inject_pkg::*; #(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adv,
  output logic [31:0] q
);
  localparam logic [31:0] INIT = SEED == 32'd0 ? 32'd1 : SEED;
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= INIT;
    else if (adv) q <= (q >> 1) ^ (q[0] ? LFSR_POLY : 32'd0);
endmodule

// File: rtl/fault_inject_seq.sv
// fault_inject_seq: alternates quiet and corrupting windows on err, picking fixed or LFSR-chosen bits
module fault_inject_seq import fault_inject_pkg::*; #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [$clog2(WIDTH)-1:0] bit_sel,
  input  logic [15:0]              gap_cycles,
  input  logic [15:0]              pulse_cycles,
  input  logic [7:0]               num_faults,
  output logic [WIDTH-1:0]         err,
  output logic                     active,
  output logic                     done,
  output logic [15:0]              fault_count
);
  localparam int LW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = 1;
  state_t state, next;
  logic [15:0] cnt, gap_load, pulse_load, new_count;
  logic [31:0] lfsr;
  logic [LW-1:0] a, b_raw, b;
  logic [WIDTH-1:0] pattern;
  logic cnt_hit, finish, unused_bits;
  fault_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk),
    .reset(reset),
    .adv(state != S_IDLE),
    .q(lfsr)
  );
  assign unused_bits = ^lfsr;
  assign a = lfsr[LW-1:0];
  assign b_raw = lfsr[2*LW-1:LW];
  assign b = b_raw == a ? LW'(a + 1) : b_raw;
  assign pattern = mode == MODE_RAND1 ? ONE << a :
                   mode == MODE_RAND2 ? (ONE << a) | (ONE << b) : ONE << bit_sel;
  // jitter widens the gap by the low LFSR byte, saturating rather than wrapping
  assign gap_load = clamp_load({1'b0, gap_cycles} + (mode == MODE_JITTER ? {9'd0, lfsr[7:0]} : 17'd0));
  assign pulse_load = clamp_load({1'b0, pulse_cycles});
  assign cnt_hit = cnt == 16'd1;
  assign new_count = fault_count == 16'hFFFF ? fault_count : fault_count + 16'd1;
  assign finish = num_faults != 8'd0 && new_count == {8'd0, num_faults};
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (!en) next = S_IDLE;
    else if (state == S_IDLE) next = S_GAP;
    else if (state == S_GAP && cnt_hit) next = S_ACTIVE;
    else if (state == S_ACTIVE && cnt_hit) next = finish ? S_DONE : S_GAP;
  end
  always_comb begin
    active = state == S_ACTIVE;
    done = state == S_DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      err <= '0;
      fault_count <= '0;
    end else begin
      err <= next != S_ACTIVE ? '0 : state == S_ACTIVE ? err : pattern;
      if (en && state == S_IDLE) begin
        cnt <= gap_load;
        fault_count <= '0;
      end else if (en && state == S_GAP) cnt <= cnt_hit ? pulse_load : cnt - 16'd1;
      else if (en && state == S_ACTIVE) begin
        cnt <= cnt_hit ? gap_load : cnt - 16'd1;
        if (cnt_hit) fault_count <= new_count;
      end
    end
endmodule

// File: tb/tb_fault_inject_seq.sv
// tb_fault_inject_seq: randomized window schedules checked against a per-window reference model
module tb_fault_inject_seq;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  logic clk = 0, reset = 1, en = 0;
  logic [1:0] mode = 0;
  logic [4:0] bit_sel = 0;
  logic [15:0] gap_cycles = 0, pulse_cycles = 0, fault_count;
  logic [7:0] num_faults = 0;
  logic [31:0] err;
  logic active, done;
  int n_cmp = 0, n_err = 0;
  logic [31:0] m_lfsr = SEED;

  fault_inject_seq dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .bit_sel(bit_sel),
    .gap_cycles(gap_cycles), .pulse_cycles(pulse_cycles), .num_faults(num_faults),
    .err(err), .active(active), .done(done), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  function automatic int gapval(input int gap, input logic [1:0] md, input logic [31:0] l);
    int g = gap + (md == 2'd3 ? int'(l & 32'hFF) : 0);
    if (g > 65535) g = 65535;
    if (g < 1) g = 1;
    return g;
  endfunction

  function automatic logic [31:0] patt(input logic [31:0] l, input logic [1:0] md, input int bs);
    logic [31:0] one = 32'd1;
    int ia = int'(l % 32);
    int ib = int'((l / 32) % 32);
    if (ib == ia) ib = (ia + 1) % 32;
    if (md == 2'd1) return one << ia;
    if (md == 2'd2) return (one << ia) | (one << ib);
    return one << bs;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [1:0] md, input int bs, input int gap, input int pulse,
                     input int nf, input int nwin, input int abort_j);
    int g, p, cnt;
    logic [31:0] pat;
    p = pulse < 1 ? 1 : pulse;
    cnt = 0;
    pat = 0;
    mode = md; bit_sel = 5'(bs); gap_cycles = 16'(gap); pulse_cycles = 16'(pulse); num_faults = 8'(nf);
    en = 1;
    g = gapval(gap, md, m_lfsr);
    tick();
    for (int w = 0; w < nwin; w++) begin
      for (int j = 0; j < g; j++) begin
        chk("gap_err", err, 0);
        chk("gap_active", {31'd0, active}, 0);
        if (w == 0 && j == 0) chk("count_clear", {16'd0, fault_count}, 0);
        if (j == g - 1) pat = patt(m_lfsr, md, bs);
        m_lfsr = step(m_lfsr);
        tick();
      end
      for (int j = 0; j < p; j++) begin
        chk("act_err", err, pat);
        chk("act_active", {31'd0, active}, 1);
        if (md == 2'd2) chk("popcount", $countones(err), 2);
        if (w == nwin - 1 && j == abort_j) begin
          en = 0;
          m_lfsr = step(m_lfsr);
          tick();
          chk("abort_err", err, 0);
          chk("abort_idle", {30'd0, active, done}, 0);
          chk("abort_count", {16'd0, fault_count}, cnt);
          return;
        end
        if (j == p - 1) begin
          cnt++;
          g = gapval(gap, md, m_lfsr);
        end
        m_lfsr = step(m_lfsr);
        tick();
      end
    end
    chk("end_done", {31'd0, done}, nf != 0 ? 1 : 0);
    chk("end_err", err, 0);
    chk("end_count", {16'd0, fault_count}, cnt);
    en = 0;
    m_lfsr = step(m_lfsr);
    tick();
    chk("idle_flags", {30'd0, active, done}, 0);
    chk("idle_count", {16'd0, fault_count}, cnt);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_err", err, 0);
    chk("rst_flags", {30'd0, active, done}, 0);
    chk("rst_count", {16'd0, fault_count}, 0);
    reset = 0;
    tick();
    run(2'd0, 0, 18, 200, 1, 1, -1);
    run(2'd0, 0, 1, 1, 3, 3, -1);
    run(2'd2, 0, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 0, 1000, -1);
    run(2'd0, int'($urandom_range(0, 31)), int'($urandom_range(1, 10)), 50, 2, 2, 10);
    run(2'd1, 0, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 4, 4, -1);
    run(2'd3, int'($urandom_range(0, 31)), int'($urandom_range(0, 20)), int'($urandom_range(1, 5)), 5, 5, -1);
    run(2'd0, int'($urandom_range(0, 31)), 0, 0, 2, 2, -1);
    mode = 2'd3; gap_cycles = 16'hFFF0; pulse_cycles = 16'd4; num_faults = 8'd1; en = 1;
    tick();
    for (int j = 0; j < 300; j++) begin
      chk("sat_gap_err", err, 0);
      m_lfsr = step(m_lfsr);
      tick();
    end
    en = 0;
    m_lfsr = step(m_lfsr);
    tick();
    mode = 2'd1; gap_cycles = 16'd2; pulse_cycles = 16'd20; num_faults = 8'd0; en = 1;
    for (int j = 0; j < 50 && !active; j++) tick();
    chk("wait_active", {31'd0, active}, 1);
    #2 reset = 1;
    #1;
    chk("async_err", err, 0);
    chk("async_active", {31'd0, active}, 0);
    en = 0;
    #1 reset = 0;
    tick();
    chk("post_rst_err", err, 0);
    chk("post_rst_flags", {30'd0, active, done}, 0);
    chk("post_rst_count", {16'd0, fault_count}, 0);
    m_lfsr = SEED;
    run(2'd1, 0, int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 3, 3, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
